// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state encoding and counter width for the memory access stage
// Purpose : types and constants shared by mem_access_stage and mem_timeout_ctr.
// Contents: state_t (IDLE=0, ACCESS=1), CTR_W (timeout counter width).
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CTR_W = 8;

endpackage : mem_stage_pkg

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - cycle counter with synchronous clear and terminal-count flag
// Purpose : counts stalled ACCESS cycles so the stage can abort a hung bus transfer.
// Ports   : clk, rst_n (async, active-low)
//           clear  - synchronous clear to zero (wins over enable)
//           enable - increment by one this cycle
//           tc     - high while the cycle in progress is the TERMINAL-th counted cycle
import mem_stage_pkg::*;

module mem_timeout_ctr #(
    parameter int TERMINAL = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CTR_W-1:0] LAST = CTR_W'(TERMINAL - 1);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The count equals the number of completed unacked ACCESS cycles, so the
    // edge that would make it TERMINAL is the one ending cycle TERMINAL.
    assign tc = (count == LAST);

endmodule : mem_timeout_ctr

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage with data-memory handshake and bus timeout
// Purpose : passes ALU results straight through, runs aligned loads/stores on a
//           req/ack data bus, and reports misalignment or bus-timeout to MEM/WB.
// Ports   : Clk, Rst_n (async, active-low)
//           In*        - instruction from EX/MEM (held by upstream while Stall=1)
//           Flush      - squash the in-flight instruction at this edge
//           Stall      - high exactly while an access is outstanding
//           Mem*       - data-memory request/acknowledge interface
//           Out*       - registered results towards MEM/WB
import mem_stage_pkg::*;

module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        InValid,
    input  logic        InWB,
    input  logic        InMemtoReg,
    input  logic        InMemRead,
    input  logic        InMemWrite,
    input  logic [31:0] InAddr,
    input  logic [31:0] InWriteData,
    input  logic [4:0]  InDest,
    input  logic        Flush,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        OutValid,
    output logic        OutWB,
    output logic        OutMemtoReg,
    output logic [31:0] OutReadData,
    output logic [31:0] OutAluResult,
    output logic [4:0]  OutDest,
    output logic        OutMisalign,
    output logic        OutBusErr
);

    state_t state, next_state;

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic        lat_wb;
    logic        lat_memtoreg;
    logic [4:0]  lat_dest;

    logic is_mem;
    logic accept_alu;
    logic accept_mis;
    logic accept_mem;
    logic done_ok;
    logic done_err;
    logic tc;

    mem_timeout_ctr #(
        .TERMINAL (TIMEOUT)
    ) u_timeout (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .clear  (state == IDLE),
        .enable ((state == ACCESS) && !MemAck),
        .tc     (tc)
    );

    assign is_mem = InMemRead | InMemWrite;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush dominates every other event; ack dominates the timeout.
    always_comb begin
        next_state = state;
        accept_alu = 1'b0;
        accept_mis = 1'b0;
        accept_mem = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state)
            IDLE: begin
                if (InValid && !Flush) begin
                    if (!is_mem) begin
                        accept_alu = 1'b1;
                    end else if (InAddr[1:0] != 2'b00) begin
                        accept_mis = 1'b1;
                    end else begin
                        accept_mem = 1'b1;
                        next_state = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (Flush) begin
                    next_state = IDLE;
                end else if (MemAck) begin
                    done_ok    = 1'b1;
                    next_state = IDLE;
                end else if (tc) begin
                    done_err   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign Stall    = (state == ACCESS);
    assign MemReq   = (state == ACCESS);
    assign MemWe    = (state == ACCESS) && lat_we;
    assign MemAddr  = lat_addr;
    assign MemWData = lat_wdata;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_we       <= 1'b0;
            lat_wb       <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_dest     <= '0;
        end else if (accept_mem) begin
            lat_addr     <= InAddr;
            lat_wdata    <= InWriteData;
            lat_we       <= InMemWrite;   // read+write together behaves as a store
            lat_wb       <= InWB;
            lat_memtoreg <= InMemtoReg;
            lat_dest     <= InDest;
        end
    end

    // Completion flags pulse for one cycle; data outputs hold between completions.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutValid     <= 1'b0;
            OutWB        <= 1'b0;
            OutMemtoReg  <= 1'b0;
            OutMisalign  <= 1'b0;
            OutBusErr    <= 1'b0;
            OutReadData  <= '0;
            OutAluResult <= '0;
            OutDest      <= '0;
        end else begin
            OutValid    <= 1'b0;
            OutWB       <= 1'b0;
            OutMisalign <= 1'b0;
            OutBusErr   <= 1'b0;
            if (accept_alu) begin
                OutValid     <= 1'b1;
                OutWB        <= InWB;
                OutMemtoReg  <= InMemtoReg;
                OutAluResult <= InAddr;
                OutDest      <= InDest;
            end else if (accept_mis) begin
                OutValid     <= 1'b1;
                OutMisalign  <= 1'b1;
                OutMemtoReg  <= InMemtoReg;
                OutAluResult <= InAddr;
                OutDest      <= InDest;
            end else if (done_ok) begin
                OutValid     <= 1'b1;
                OutWB        <= lat_wb;
                OutMemtoReg  <= lat_memtoreg;
                OutAluResult <= lat_addr;
                OutDest      <= lat_dest;
                if (!lat_we) begin
                    OutReadData <= MemRData;
                end
            end else if (done_err) begin
                OutValid     <= 1'b1;
                OutBusErr    <= 1'b1;
                OutMemtoReg  <= lat_memtoreg;
                OutAluResult <= lat_addr;
                OutDest      <= lat_dest;
            end
        end
    end

endmodule : mem_access_stage

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        InValid = 1'b0;
    logic        InWB = 1'b0;
    logic        InMemtoReg = 1'b0;
    logic        InMemRead = 1'b0;
    logic        InMemWrite = 1'b0;
    logic [31:0] InAddr = '0;
    logic [31:0] InWriteData = '0;
    logic [4:0]  InDest = '0;
    logic        Flush = 1'b0;
    logic        Stall;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;
    logic        OutValid;
    logic        OutWB;
    logic        OutMemtoReg;
    logic [31:0] OutReadData;
    logic [31:0] OutAluResult;
    logic [4:0]  OutDest;
    logic        OutMisalign;
    logic        OutBusErr;

    int checks = 0;
    int fails  = 0;
    int stall_cnt;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .InValid      (InValid),
        .InWB         (InWB),
        .InMemtoReg   (InMemtoReg),
        .InMemRead    (InMemRead),
        .InMemWrite   (InMemWrite),
        .InAddr       (InAddr),
        .InWriteData  (InWriteData),
        .InDest       (InDest),
        .Flush        (Flush),
        .Stall        (Stall),
        .MemReq       (MemReq),
        .MemWe        (MemWe),
        .MemAddr      (MemAddr),
        .MemWData     (MemWData),
        .MemAck       (MemAck),
        .MemRData     (MemRData),
        .OutValid     (OutValid),
        .OutWB        (OutWB),
        .OutMemtoReg  (OutMemtoReg),
        .OutReadData  (OutReadData),
        .OutAluResult (OutAluResult),
        .OutDest      (OutDest),
        .OutMisalign  (OutMisalign),
        .OutBusErr    (OutBusErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        InValid = 0; InWB = 0; InMemtoReg = 0; InMemRead = 0; InMemWrite = 0;
        MemAck = 0; Flush = 0;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_stall", 32'(Stall), 0);
        check("rst_memreq", 32'(MemReq), 0);
        check("rst_memwe", 32'(MemWe), 0);
        check("rst_outvalid", 32'(OutValid), 0);
        check("rst_readdata", OutReadData, 0);
        check("rst_aluresult", OutAluResult, 0);
        #10;
        Rst_n = 1'b1;
        tick();

        // ALU pass-through, one-cycle latency, no stall
        InValid = 1; InAddr = 32'h10; InDest = 5'd5; InWB = 1;
        check("alu_stall_pre", 32'(Stall), 0);
        tick();
        check("alu_valid", 32'(OutValid), 1);
        check("alu_result", OutAluResult, 32'h10);
        check("alu_dest", 32'(OutDest), 5);
        check("alu_wb", 32'(OutWB), 1);
        check("alu_stall", 32'(Stall), 0);
        idle_inputs();
        tick();
        check("alu_valid_drop", 32'(OutValid), 0);
        check("alu_result_hold", OutAluResult, 32'h10);

        // load with ack in third ACCESS cycle
        InValid = 1; InAddr = 32'h100; InDest = 5'd7; InWB = 1; InMemtoReg = 1; InMemRead = 1;
        stall_cnt = 0;
        tick();
        check("ld_memreq", 32'(MemReq), 1);
        check("ld_memwe", 32'(MemWe), 0);
        check("ld_memaddr", MemAddr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            if (Stall) stall_cnt++;
            if (i == 2) begin MemAck = 1; MemRData = 32'hDEADBEEF; end
            tick();
        end
        check("ld_stall_cycles", 32'(stall_cnt), 3);
        check("ld_valid", 32'(OutValid), 1);
        check("ld_readdata", OutReadData, 32'hDEADBEEF);
        check("ld_memtoreg", 32'(OutMemtoReg), 1);
        check("ld_dest", 32'(OutDest), 7);
        check("ld_stall_after", 32'(Stall), 0);
        check("ld_memreq_after", 32'(MemReq), 0);
        idle_inputs();
        tick();
        check("ld_valid_one_cycle", 32'(OutValid), 0);
        check("ld_readdata_hold", OutReadData, 32'hDEADBEEF);

        // misaligned store
        InValid = 1; InAddr = 32'h102; InMemWrite = 1; InWriteData = 32'h11112222; InWB = 1;
        check("mis_memreq_pre", 32'(MemReq), 0);
        tick();
        check("mis_valid", 32'(OutValid), 1);
        check("mis_flag", 32'(OutMisalign), 1);
        check("mis_wb", 32'(OutWB), 0);
        check("mis_memreq", 32'(MemReq), 0);
        idle_inputs();
        tick();
        check("mis_flag_drop", 32'(OutMisalign), 0);

        // read+write treated as store, minimum latency ack
        InValid = 1; InAddr = 32'h200; InWriteData = 32'hCAFEF00D; InMemRead = 1; InMemWrite = 1;
        tick();
        check("st_memwe", 32'(MemWe), 1);
        check("st_wdata", MemWData, 32'hCAFEF00D);
        check("st_stall_ack_cycle", 32'(Stall), 1);
        MemAck = 1; MemRData = 32'h12345678;
        tick();
        check("st_valid", 32'(OutValid), 1);
        check("st_readdata_hold", OutReadData, 32'hDEADBEEF);
        check("st_stall_after", 32'(Stall), 0);
        idle_inputs();
        tick();

        // timeout: 16 unacked ACCESS cycles
        InValid = 1; InAddr = 32'h300; InMemRead = 1; InWB = 1; InDest = 5'd3;
        tick();
        stall_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (Stall && !OutBusErr) stall_cnt++;
            tick();
        end
        check("to_stall_15", 32'(stall_cnt), 15);
        check("to_not_yet", 32'(OutValid), 0);
        tick();
        check("to_buserr", 32'(OutBusErr), 1);
        check("to_valid", 32'(OutValid), 1);
        check("to_wb", 32'(OutWB), 0);
        check("to_memreq", 32'(MemReq), 0);
        idle_inputs();
        tick();
        check("to_buserr_drop", 32'(OutBusErr), 0);

        // ack in the same cycle the timeout would fire
        InValid = 1; InAddr = 32'h400; InMemRead = 1; InWB = 1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        MemAck = 1; MemRData = 32'hA5A55A5A;
        tick();
        check("ackwin_buserr", 32'(OutBusErr), 0);
        check("ackwin_valid", 32'(OutValid), 1);
        check("ackwin_data", OutReadData, 32'hA5A55A5A);
        check("ackwin_wb", 32'(OutWB), 1);
        idle_inputs();
        tick();

        // flush with ack in ACCESS
        InValid = 1; InAddr = 32'h500; InMemRead = 1; InWB = 1;
        tick();
        Flush = 1; MemAck = 1; MemRData = 32'hFFFF0000;
        tick();
        check("fl_valid", 32'(OutValid), 0);
        check("fl_readdata", OutReadData, 32'hA5A55A5A);
        check("fl_stall", 32'(Stall), 0);
        check("fl_memreq", 32'(MemReq), 0);
        idle_inputs();

        // ack while idle is ignored
        MemAck = 1; MemRData = 32'h0BADF00D;
        tick();
        check("idleack_valid", 32'(OutValid), 0);
        check("idleack_data", OutReadData, 32'hA5A55A5A);
        idle_inputs();
        tick();

        // asynchronous reset mid-ACCESS
        InValid = 1; InAddr = 32'h600; InMemRead = 1; InWB = 1;
        tick();
        check("ar_in_access", 32'(Stall), 1);
        #2;
        Rst_n = 0;
        #1;
        check("ar_memreq", 32'(MemReq), 0);
        check("ar_stall", 32'(Stall), 0);
        check("ar_readdata", OutReadData, 0);
        check("ar_aluresult", OutAluResult, 0);
        check("ar_dest", 32'(OutDest), 0);
        idle_inputs();
        tick();
        Rst_n = 1;
        tick();
        check("ar_no_completion", 32'(OutValid), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule : tb_mem_access_stage

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum cycles in ACCESS before a bus-error abort (range 2..255).
REQ-002 Clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Rst_n  in  1  reset, SHALL be asynchronous and active-low.
REQ-004 InValid  in  1  upstream instruction present; InWB, InMemtoReg, InMemRead, InMemWrite  in  1 each  control bits.
REQ-005 InAddr  in  32  ALU result/address; InWriteData  in  32  store data; InDest  in  5  destination register.
REQ-006 Flush  in  1  synchronous squash of the in-flight instruction.
REQ-007 Stall  out  1  SHALL be high exactly when state is ACCESS; upstream SHALL hold its inputs while Stall is high.
REQ-008 MemReq, MemWe  out  1 each; MemAddr, MemWData  out  32 each; MemAck  in  1; MemRData  in  32  data-memory handshake.
REQ-009 OutValid, OutWB, OutMemtoReg  out  1 each; OutReadData, OutAluResult  out  32 each; OutDest  out  5; OutMisalign, OutBusErr  out  1 each  to MEM/WB register.

Function
REQ-010 States SHALL be IDLE and ACCESS only.
REQ-011 IDLE, InValid with neither MemRead nor MemWrite: next edge SHALL register OutAluResult=InAddr, OutDest, OutWB, OutMemtoReg, OutValid=1 (1-cycle latency); state stays IDLE.
REQ-012 IDLE, InValid with MemRead or MemWrite and InAddr[1:0]=0: next edge SHALL latch address, data, controls, dest, and go ACCESS.
REQ-013 IDLE, memory access with InAddr[1:0]!=0: no request SHALL be issued; next edge SHALL produce OutValid=1, OutMisalign=1, OutWB=0.
REQ-014 MemRead and MemWrite both set SHALL be treated as a write.
REQ-015 In ACCESS: MemReq=1, MemWe=latched write flag, MemAddr/MemWData SHALL be held stable from latched values; MemReq=0 in IDLE.
REQ-016 At the edge where MemAck=1 is sampled in ACCESS: go IDLE, OutValid=1, OutReadData=MemRData for reads (held unchanged for writes), other outputs from latched values.
REQ-017 Minimum memory-op latency SHALL be 2 cycles (ack in first ACCESS cycle); Stall SHALL still be high in the ack cycle, next instruction accepted the cycle after.
REQ-018 Timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; on reaching TIMEOUT: go IDLE, OutValid=1, OutBusErr=1, OutWB=0.
REQ-019 MemAck in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-020 Cycles with no completion SHALL drive OutValid=0, OutWB=0, OutMisalign=0, OutBusErr=0; data outputs SHALL hold.
REQ-021 Flush=1 SHALL, at that edge, force IDLE, OutValid=0, OutWB=0 and discard any MemAck/data (Flush wins over ack and timeout); an already-acked store is not undone.
REQ-022 MemAck while IDLE SHALL be ignored.

Reset
REQ-023 Rst_n low SHALL immediately force IDLE, counter=0, MemReq=0, MemWe=0, Stall=0, all Out* flags 0, all data outputs 0.
REQ-024 Reset mid-ACCESS SHALL abandon the request with no completion reported.

Structure
REQ-025 Shared package mem_stage_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1) and timeout counter width (8).
REQ-026 One sub-module, mem_timeout_ctr (clear, enable, terminal-count flag), SHALL implement the counter; FSM and output registers live in mem_access_stage.

Verification
REQ-027 ALU op InAddr=0x0000_0010, InDest=5, InWB=1 -> next edge OutValid=1, OutAluResult=0x10, OutDest=5, Stall never high.
REQ-028 Load 0x0000_0100, MemAck after 3 cycles with MemRData=0xDEAD_BEEF -> Stall high 3 cycles, OutReadData=0xDEADBEEF, OutMemtoReg=1, OutValid one cycle.
REQ-029 Store to 0x0000_0102 -> MemReq never high, OutMisalign=1, OutWB=0, OutValid=1 next edge.
REQ-030 Load, MemAck never, TIMEOUT=16 -> abort after 16 ACCESS cycles, OutBusErr=1, MemReq low next cycle.
REQ-031 Load in ACCESS, Flush and MemAck same cycle -> OutValid=0, OutReadData unchanged, state IDLE.
REQ-032 Rst_n low mid-ACCESS (not clock aligned) -> MemReq and Stall drop immediately, all outputs 0.
